// File: rtl/sw_pkg.sv
// Shared switch-path constants used by the debouncer and the display stage.
package sw_pkg;

  // Number of board switches.
  localparam int SW_W = 4;

  // Default debounce hold time in clock cycles.
  localparam int unsigned DB_CYCLES_DEF = 16;

  // Default switch value assumed while in reset.
  localparam logic [SW_W-1:0] RESET_VAL_DEF = 4'hF;

  // One switch word as seen by downstream stages.
  typedef logic [SW_W-1:0] sw_vec_t;

  // Counter width able to hold 0..n-1; at least one bit.
  function automatic int cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch bit: 2-flop synchronizer, saturating hold counter and
// the accepted (stable) value.
module sw_db_bit
  import sw_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter logic        RESET_BIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int            CW      = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count how long the synchronized bit has disagreed with the stable
  // value; accept it once it has disagreed for DB_CYCLES edges in a row.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_o = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
      accept_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, counter and stable flop; reset forces the assumed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= RESET_BIT;
      s2_q     <= RESET_BIT;
      stable_q <= RESET_BIT;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sw_debounce.sv
// Four-bit switch debouncer. Each bit is debounced independently;
// sw_change pulses for one cycle whenever sw_stable takes a new value.
// Define SW_DEBOUNCE_EDGE_EN to add per-bit sw_rise/sw_fall pulses.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned     DB_CYCLES = DB_CYCLES_DEF,
  parameter logic [SW_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] switch,
  output logic [SW_W-1:0] sw_stable,
  output logic            sw_change
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [SW_W-1:0] sw_rise,
  output logic [SW_W-1:0] sw_fall
`endif
);

  sw_vec_t stable_w;
  sw_vec_t accept_w;
  logic    change_q;

  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_bit
      sw_db_bit #(
        .DB_CYCLES (DB_CYCLES),
        .RESET_BIT (RESET_VAL[gi])
      ) u_bit (
        .clk      (clk),
        .reset    (reset),
        .sw_i     (switch[gi]),
        .stable_o (stable_w[gi]),
        .accept_o (accept_w[gi])
      );
    end
  endgenerate

  // A bit accepting now flips sw_stable on this edge, so registering the
  // accept strobes lines the pulse up with the new sw_stable value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_q <= 1'b0;
    end else begin
      change_q <= |accept_w;
    end
  end

  assign sw_stable = stable_w;
  assign sw_change = change_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  sw_vec_t rise_q;
  sw_vec_t fall_q;

  // Direction of each accepted flip is the inverse of its current value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= accept_w & ~stable_w;
      fall_q <= accept_w & stable_w;
    end
  end

  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`endif

endmodule
